// File: rtl/pc_gen_pkg.sv
// Shared constants and types for the program-counter generator:
// branch funct3 codes, mtvec modes and the fetch FSM states.
package pc_gen_pkg;

    localparam int unsigned MXLEN = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Only VECTORED changes the trap target; modes 00, 10 and 11 all behave as direct.
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    typedef enum logic [1:0] {
        StReset,
        StFetch,
        StExec,
        StFault
    } pc_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Instruction-fetch request bus: the PC generator (master) offers pc_val,
// and the instruction memory (slave) accepts it with fetch_ready.
interface pc_gen_if import pc_gen_pkg::*; #(
    parameter int unsigned XLEN = MXLEN
) ();

    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] pc_val;

    modport master (
        output fetch_valid,
        output pc_val,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  pc_val,
        output fetch_ready
    );

endinterface

// File: rtl/pc_gen_br_resolve.sv
// Combinational control-transfer resolver: branch condition, JAL/JALR/branch
// target and target misalignment for the configured instruction alignment.
module pc_gen_br_resolve import pc_gen_pkg::*; #(
    parameter int unsigned XLEN   = MXLEN,
    parameter int unsigned IALIGN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic            cmp_eq_i,
    input  logic            cmp_lt_i,
    input  logic            cmp_ltu_i,
    input  logic            is_jalr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_val_i,
    output logic            taken_o,
    output logic [XLEN-1:0] target_o,
    output logic            misaligned_o
);

    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            F3_BEQ:  taken_o = cmp_eq_i;
            F3_BNE:  taken_o = ~cmp_eq_i;
            F3_BLT:  taken_o = cmp_lt_i;
            F3_BGE:  taken_o = ~cmp_lt_i;
            F3_BLTU: taken_o = cmp_ltu_i;
            F3_BGEU: taken_o = ~cmp_ltu_i;
            default: taken_o = 1'b0;
        endcase
    end

    always_comb begin
        target_o = (is_jalr_i ? rs1_val_i : pc_i) + imm_i;
        if (is_jalr_i) begin
            target_o[0] = 1'b0;
        end
    end

    assign misaligned_o = (IALIGN == 16) ? target_o[0] : (|target_o[1:0]);

endmodule

// File: rtl/pc_gen.sv
// Architectural PC owner: drives instruction fetch, resolves the next PC
// (trap, mret, jumps, branches, sequential) and parks misaligned targets.
module pc_gen import pc_gen_pkg::*; #(
    parameter int unsigned    XLEN    = MXLEN,
    parameter logic [XLEN-1:0] RST_VEC = '0,
    parameter int unsigned    IALIGN  = 32
) (
    input  logic            CLK,
    input  logic            RST,
    pc_gen_if.master        fetch,
    input  logic            instr_done_i,
    input  logic            is_branch_i,
    input  logic            is_jal_i,
    input  logic            is_jalr_i,
    input  logic [2:0]      funct3_i,
    input  logic            cmp_eq_i,
    input  logic            cmp_lt_i,
    input  logic            cmp_ltu_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_val_i,
    input  logic            instr_len16_i,
    input  logic            exception_i,
    input  logic            trap_is_irq_i,
    input  logic [4:0]      trap_cause_i,
    input  logic            mret_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    output logic [XLEN-1:0] pc_link_o,
    output logic            i_misaligned_o,
    output logic [XLEN-1:0] bad_target_o
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] bad_q, bad_d;

    logic            br_taken;
    logic            tgt_misaligned;
    logic [XLEN-1:0] tgt;
    logic            xfer;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] trap_vec;

    pc_gen_br_resolve #(
        .XLEN   (XLEN),
        .IALIGN (IALIGN)
    ) u_br_resolve (
        .funct3_i     (funct3_i),
        .cmp_eq_i     (cmp_eq_i),
        .cmp_lt_i     (cmp_lt_i),
        .cmp_ltu_i    (cmp_ltu_i),
        .is_jalr_i    (is_jalr_i),
        .pc_i         (pc_q),
        .imm_i        (imm_i),
        .rs1_val_i    (rs1_val_i),
        .taken_o      (br_taken),
        .target_o     (tgt),
        .misaligned_o (tgt_misaligned)
    );

    assign xfer = is_jalr_i | is_jal_i | (is_branch_i & br_taken);

    assign pc_link_o = pc_q + (((IALIGN == 16) && instr_len16_i) ? XLEN'(2) : XLEN'(4));

    assign tvec_base = {mtvec_i[XLEN-1:2], 2'b00};
    assign trap_vec  = (trap_is_irq_i && (mtvec_i[1:0] == MTVEC_MODE_VECTORED)) ?
                       tvec_base + {{(XLEN-7){1'b0}}, trap_cause_i, 2'b00} : tvec_base;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        bad_d   = bad_q;
        case (state_q)
            StReset: state_d = StFetch;
            StFetch: begin
                if (fetch.fetch_ready) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (instr_done_i) begin
                    state_d = StFetch;
                    if (exception_i) begin
                        pc_d = trap_vec;
                    end else if (mret_i) begin
                        pc_d = mepc_i;
                    end else if (xfer && tgt_misaligned) begin
                        // PC stays on the faulting instruction; the target goes to mtval.
                        bad_d   = tgt;
                        state_d = StFault;
                    end else if (xfer) begin
                        pc_d = tgt;
                    end else begin
                        pc_d = pc_link_o;
                    end
                end
            end
            StFault: begin
                if (exception_i) begin
                    pc_d    = trap_vec;
                    state_d = StFetch;
                end
            end
            default: state_d = StReset;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StReset;
            pc_q    <= RST_VEC;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            bad_q   <= bad_d;
        end
    end

    assign fetch.fetch_valid = (state_q == StFetch);
    assign fetch.pc_val      = pc_q;
    assign i_misaligned_o    = (state_q == StFault);
    assign bad_target_o      = bad_q;

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised program-counter generator for the RV32 core, replacing the fixed-width, always-advance PC register. It owns the architectural PC and drives instruction fetch through a valid/ready handshake. It resolves branch, JAL, JALR, trap-entry and MRET targets, including vectored trap entry. Misaligned targets are detected and held until the trap controller takes them. It sits between the decoder/ALU, the CSR file and the instruction-memory port.

## Interface
- `XLEN`, 32: PC and operand width.
- `RST_VEC`, 0: PC value after reset.
- `IALIGN`, 32: instruction alignment, 32 or 16; 16 enables 2-byte sequential steps.

- `CLK` in 1: clock.
- `RST` in 1: reset, synchronous, active-high.
- `fetch_valid` out 1: fetch request for `pc_val`.
- `fetch_ready` in 1: memory accepts the request.
- `instr_done` in 1: instruction at `pc_val` completes; all decode inputs are valid this cycle.
- `is_branch` in 1: conditional branch.
- `is_jal` in 1: JAL.
- `is_jalr` in 1: JALR.
- `funct3` in 3: branch condition.
- `cmp_eq` in 1: ALU compare flag, rs1==rs2.
- `cmp_lt` in 1: ALU compare flag, signed rs1<rs2.
- `cmp_ltu` in 1: ALU compare flag, unsigned rs1<rs2.
- `imm` in XLEN: sign-extended immediate.
- `rs1_val` in XLEN: JALR base.
- `instr_len16` in 1: current instruction is 2 bytes; ignored when IALIGN=32.
- `exception` in 1: trap entry.
- `trap_is_irq` in 1: trap is an interrupt.
- `trap_cause` in 5: trap cause.
- `mret` in 1: return from trap.
- `mtvec` in XLEN: CSR value.
- `mepc` in XLEN: CSR value.
- `pc_val` out XLEN: current PC.
- `pc_link` out XLEN: pc_val + 4, or + 2 when instr_len16 and IALIGN=16.
- `i_misaligned` out 1: misaligned control-transfer target pending.
- `bad_target` out XLEN: misaligned target value, used for mtval.

## Operation
- FSM states:
  - S_RESET: fetch_valid=0.
  - S_FETCH: fetch_valid=1.
  - S_EXEC: waiting for instr_done.
  - S_FAULT: i_misaligned=1.
- Reset values: pc_val=RST_VEC, state S_RESET, fetch_valid=0, i_misaligned=0, bad_target=0.
- S_RESET -> S_FETCH unconditionally.
- S_FETCH -> S_EXEC on fetch_valid & fetch_ready.
- S_EXEC:
  - instr_done=0: stay.
  - instr_done=1: load pc_val with next PC and go to S_FETCH, or to S_FAULT on a misaligned target.
- Next-PC priority (first match wins):
  - exception: trap vector.
  - mret: mepc (no +4).
  - is_jalr: (rs1_val+imm) & ~1.
  - is_jal: pc_val+imm.
  - is_branch and taken: pc_val+imm.
  - otherwise: pc_link.
- Branch condition by funct3:
  - BEQ: cmp_eq.
  - BNE: !cmp_eq.
  - BLT: cmp_lt.
  - BGE: !cmp_lt.
  - BLTU: cmp_ltu.
  - BGEU: !cmp_ltu.
  - 010 and 011: not taken.
- Trap vector:
  - base = {mtvec[XLEN-1:2],2'b00}.
  - If mtvec[1:0]==01 and trap_is_irq, target is base + 4*trap_cause; otherwise base.
  - mtvec[1:0] of 10 or 11 is treated as direct.
- Misalignment:
  - Checked only for the JAL, JALR and taken-branch targets.
  - Condition: target[1:0]!=0 when IALIGN=32, target[0]!=0 when IALIGN=16. JALR already clears bit 0, so only bit 1 matters there.
  - On misalignment: pc_val is unchanged, bad_target latches the target, state goes to S_FAULT.
- S_FAULT:
  - Only exception is acted on: pc_val loads the trap vector, i_misaligned clears, next state S_FETCH.
  - All other inputs are ignored.
- All additions wrap modulo 2^XLEN.

## Timing
- pc_val is stable from entry to S_FETCH until the edge following instr_done (or exception in S_FAULT).
- Minimum throughput: 2 cycles per instruction, with fetch_ready=1 and instr_done in the first S_EXEC cycle.
- fetch_valid holds until the transfer completes; pc_val never changes while fetch_valid=1.
- instr_done, exception and mret outside S_EXEC (and exception outside S_FAULT) are ignored.
- Simultaneous exception and mret: exception wins.
- RST in any state returns all outputs to reset values at the next edge; no pending fault survives.
- pc_link is combinational from pc_val and instr_len16.

## Structure
- Shared `defs.v` holds:
  - MXLEN.
  - F3_BEQ..F3_BGEU constants.
  - The state encodings S_RESET/S_FETCH/S_EXEC/S_FAULT.
  - MTVEC_MODE_DIRECT/VECTORED.
- One combinational sub-module, `pc_br_resolve`:
  - Inputs: funct3 and the compare flags.
  - Outputs: taken, the selected target, and the misaligned flag.
- pc_gen keeps the FSM, the registers and the priority mux.

## Test plan
- Reset with RST_VEC=0x100, fetch_ready=1: S_RESET for 1 cycle, fetch_valid rises, pc_val=0x100, then 0x104 after instr_done with no control transfer.
- fetch_ready held 0 for 5 cycles with instr_done pulsed: fetch_valid stays 1, pc_val constant, instr_done ignored.
- BGE at pc=0x200, imm=-8, cmp_lt=0 -> 0x1F8; cmp_lt=1 -> 0x204; funct3=010 -> 0x204.
- JAL at 0x300, imm=6, IALIGN=32: i_misaligned=1, bad_target=0x306, pc stays 0x300. Then exception with mtvec=0x1000 -> pc=0x1000, i_misaligned=0.
- mtvec=0x1001, trap_is_irq=1, trap_cause=7 -> pc=0x101C. Same with trap_is_irq=0 -> 0x1000. mret with mepc=0x444 -> 0x444.
- IALIGN=16, instr_len16=1 at 0x10 -> pc_link=0x12, next pc 0x12. RST asserted in S_FAULT -> pc=RST_VEC, i_misaligned=0.
